// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg - shared encodings for the PC sequencer and control unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    EXC_NONE   = 2'b00,
    EXC_OPCODE = 2'b01,
    EXC_OVF    = 2'b10,
    EXC_DIV0   = 2'b11
  } exc_code_t;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LE = 2'b10,
    BR_GT = 2'b11
  } branch_type_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXC_ADDR = 2'b01,
    ST_EXC_WAIT = 2'b10,
    ST_EXC_LOAD = 2'b11
  } state_t;

  // Wait counter only has to hold MEM_LAT-1 for MEM_LAT in 1..3
  localparam int unsigned C_CNT_W   = 2;
  localparam logic [31:0] C_PC_STEP = 32'd4;

  // Vector for code 01 sits at base+0, 10 at base+1, 11 at base+2
  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [1:0]  code);
    return base + {30'b0, code} - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if - control/datapath bundle between control unit and sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if;

  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        zero;
  logic        gt;
  logic [1:0]  exc_code;
  logic [7:0]  mem_byte;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] vec_addr;
  logic        vec_sel;
  logic        busy;
  logic        exc_done;

  modport master (
    output next_pc, pc_write, pc_write_cond, branch_type, zero, gt,
           exc_code, mem_byte,
    input  pc, epc, vec_addr, vec_sel, busy, exc_done
  );

  modport slave (
    input  next_pc, pc_write, pc_write_cond, branch_type, zero, gt,
           exc_code, mem_byte,
    output pc, epc, vec_addr, vec_sel, busy, exc_done
  );

endinterface

`default_nettype wire

// File: rtl/pc_sequencer_branch_cond.sv
// ----------------------------------------------------------------------------
// branch_cond - combinational branch-condition decode from ALU flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_cond
  import pc_sequencer_pkg::*;
(
  input  logic [1:0] branch_type,
  input  logic       zero,
  input  logic       gt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BR_EQ:   cond = zero;
      BR_NE:   cond = ~zero;
      BR_LE:   cond = ~gt;
      BR_GT:   cond = gt;
      default: cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer - PC/EPC registers, branch writes and exception-entry sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [C_CNT_W-1:0] C_WAIT_INIT = C_CNT_W'(MEM_LAT - 1);
  localparam logic [31:0]        C_VEC_BASE  = 32'(VEC_BASE);

  logic w_cond;
  logic w_take;

  state_t             r_state;
  logic [C_CNT_W-1:0] r_wait_cnt;
  logic [31:0]        r_pc;
  logic [31:0]        r_epc;
  logic [31:0]        r_vec_addr;
  logic               r_vec_sel;
  logic               r_busy;
  logic               r_exc_done;

  branch_cond u_branch_cond (
    .branch_type (bus.branch_type),
    .zero        (bus.zero),
    .gt          (bus.gt),
    .cond        (w_cond)
  );

  assign w_take = bus.pc_write | (bus.pc_write_cond & w_cond);

  // Status outputs are registered alongside the state so they always match
  // a pure decode of the state they accompany.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_pc       <= RESET_PC;
      r_epc      <= 32'h0;
      r_vec_addr <= 32'h0;
      r_vec_sel  <= 1'b0;
      r_busy     <= 1'b0;
      r_exc_done <= 1'b0;
    end else begin
      r_exc_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.exc_code != EXC_NONE) begin
            // Exception wins over any PC write presented on the same edge
            r_epc      <= r_pc - C_PC_STEP;
            r_vec_addr <= vector_addr(C_VEC_BASE, bus.exc_code);
            r_vec_sel  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_EXC_ADDR;
          end else if (w_take) begin
            r_pc <= bus.next_pc;
          end
        end
        ST_EXC_ADDR: begin
          r_wait_cnt <= C_WAIT_INIT;
          r_state    <= ST_EXC_WAIT;
        end
        ST_EXC_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_vec_sel  <= 1'b0;
            r_exc_done <= 1'b1;
            r_state    <= ST_EXC_LOAD;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        ST_EXC_LOAD: begin
          r_pc    <= {24'b0, bus.mem_byte};
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_vec_sel <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.epc      = r_epc;
  assign bus.vec_addr = r_vec_addr;
  assign bus.vec_sel  = r_vec_sel;
  assign bus.busy     = r_busy;
  assign bus.exc_done = r_exc_done;

endmodule

`default_nettype wire
